reg_dump_sequencer: RTL and testbench

Controller that sweeps the simulated register file and feeds the VGA text path. It drives `addr`, samples `register_value` after a fixed read latency, and converts each 32-bit word into ASCII hex characters. Those characters go out one per handshake to the character writer inside `vga_demo`. It pulses `finished_register` once a full sweep completes.

---
 rtl/reg_dump_pkg.sv | 25 ++
 rtl/reg_dump_sequencer_nibble_to_ascii.sv | 22 ++
 rtl/reg_dump_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_reg_dump_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg
//   Shared definitions for the register dump sequencer: the sweep FSM state
//   encoding, the ASCII constants used to build hex text, and the per-row
//   character counts (value digits and the optional "Rxx:" label prefix).
package reg_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_CAPTURE,
    ST_EMIT,
    ST_NEXT,
    ST_DONE
  } state_e;

  localparam logic [7:0] ASCII_R     = 8'h52;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_A     = 8'h41;

  // Characters per row: 8 hex digits of the value, 4 for the "Rxx:" label.
  localparam int unsigned K_VALUE = 8;
  localparam int unsigned K_LABEL = 4;

endpackage

// File: rtl/reg_dump_sequencer_nibble_to_ascii.sv
// nibble_to_ascii
//   Combinational hex digit encoder: 0-9 -> '0'-'9', A-F -> 'A'-'F'
//   (uppercase). Used for both value digits and label digits.
// Ports:
//   nibble_i  in   4  hex digit
//   ascii_o   out  8  ASCII code of the digit
module nibble_to_ascii
  import reg_dump_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] ascii_o
);

  always_comb begin
    if (nibble_i < 4'd10) begin
      ascii_o = ASCII_ZERO + {4'd0, nibble_i};
    end else begin
      ascii_o = ASCII_A + {4'd0, nibble_i} - 8'd10;
    end
  end

endmodule

// File: rtl/reg_dump_sequencer.sv
// reg_dump_sequencer
//   Sweeps a register source from index 0 to NUM_REGS-1, waits READ_LATENCY
//   cycles for each read, snapshots the 32-bit word and emits it as eight
//   uppercase hex characters (MSB nibble first) over a valid/ready character
//   interface, one text row per register. Pulses finished_register for one
//   cycle at the end of each sweep.
//
// Optional feature (compile-time macro REG_DUMP_LABEL_EN):
//   When defined, each row is prefixed by "R", two hex digits of the row
//   index and ":", so a row is 12 characters and the value starts 4 columns
//   further right. When undefined the row is just the 8 value digits.
//
// Ports:
//   CLOCK_50           in   1   clock, all state on the rising edge
//   resetn             in   1   synchronous active-low reset
//   start              in   1   begin a sweep (ignored while busy)
//   busy               out  1   sweep in progress, up to and including DONE
//   addr               out  9   register index presented to the source
//   register_value     in   32  register contents from the source
//   finished_register  out  1   one-cycle pulse at the end of a sweep
//   char_valid         out  1   character payload valid
//   char_ready         in   1   writer accepts the character
//   char_x             out  7   text column
//   char_y             out  6   text row
//   char_code          out  8   ASCII code
module reg_dump_sequencer
  import reg_dump_pkg::*;
#(
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned COL_BASE     = 0,
  parameter int unsigned ROW_BASE     = 0
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        start,
  output logic        busy,
  output logic [8:0]  addr,
  input  logic [31:0] register_value,
  output logic        finished_register,
  output logic        char_valid,
  input  logic        char_ready,
  output logic [6:0]  char_x,
  output logic [5:0]  char_y,
  output logic [7:0]  char_code
);

`ifdef REG_DUMP_LABEL_EN
  localparam int unsigned K_CHARS = K_VALUE + K_LABEL;
`else
  localparam int unsigned K_CHARS = K_VALUE;
`endif

  localparam logic [3:0] LAST_CHR = 4'(K_CHARS - 1);
  localparam logic [8:0] LAST_IDX = 9'(NUM_REGS - 1);
  localparam logic [2:0] LAT_INIT = 3'(READ_LATENCY - 1);
  localparam logic [6:0] COL0     = 7'(COL_BASE);
  localparam logic [5:0] ROW0     = 6'(ROW_BASE);

  state_e      state_q;
  logic [8:0]  idx_q;
  logic [2:0]  lat_q;
  logic [3:0]  chr_q;
  logic [31:0] shadow_q;
  logic        busy_q;
  logic        fin_q;
  logic        valid_q;
  logic [6:0]  x_q;
  logic [5:0]  y_q;
  logic [7:0]  code_q;

  // Payload of the character that will be presented next. In CAPTURE it is
  // character 0 built straight from register_value (the shadow is being
  // loaded on the same edge); in EMIT it is character chr_q+1 of the shadow.
  logic [3:0]  chr_d;
  logic [31:0] word_d;
  logic [2:0]  val_pos_d;
  logic [3:0]  nib_d;
  logic [7:0]  hex_d;
  logic [7:0]  code_d;
  logic [6:0]  x_d;
  logic [5:0]  y_d;

  always_comb begin
    chr_d  = (state_q == ST_CAPTURE) ? 4'd0 : chr_q + 4'd1;
    word_d = (state_q == ST_CAPTURE) ? register_value : shadow_q;
`ifdef REG_DUMP_LABEL_EN
    val_pos_d = 3'(chr_d - 4'(K_LABEL));
`else
    val_pos_d = chr_d[2:0];
`endif
    // Digit position p selects bits [31-4p -: 4]; (7-p)*4 == {~p, 2'b00}.
    nib_d = word_d[{~val_pos_d, 2'b00} +: 4];
`ifdef REG_DUMP_LABEL_EN
    if (chr_d == 4'd1) begin
      nib_d = idx_q[7:4];
    end else if (chr_d == 4'd2) begin
      nib_d = idx_q[3:0];
    end
`endif
    x_d = COL0 + {3'd0, chr_d};
    y_d = ROW0 + idx_q[5:0];
  end

  nibble_to_ascii u_hex (
    .nibble_i (nib_d),
    .ascii_o  (hex_d)
  );

  always_comb begin
    code_d = hex_d;
`ifdef REG_DUMP_LABEL_EN
    if (chr_d == 4'd0) begin
      code_d = ASCII_R;
    end else if (chr_d == 4'd3) begin
      code_d = ASCII_COLON;
    end
`endif
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      lat_q    <= '0;
      chr_q    <= '0;
      shadow_q <= '0;
      busy_q   <= 1'b0;
      fin_q    <= 1'b0;
      valid_q  <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      code_q   <= '0;
    end else begin
      fin_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            idx_q   <= '0;
            lat_q   <= LAT_INIT;
            busy_q  <= 1'b1;
            state_q <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (lat_q == 3'd0) begin
            state_q <= ST_CAPTURE;
          end else begin
            lat_q <= lat_q - 3'd1;
          end
        end
        ST_CAPTURE: begin
          shadow_q <= register_value;
          chr_q    <= chr_d;
          valid_q  <= 1'b1;
          x_q      <= x_d;
          y_q      <= y_d;
          code_q   <= code_d;
          state_q  <= ST_EMIT;
        end
        ST_EMIT: begin
          // char_valid is always high here, so ready alone completes a transfer.
          if (char_ready) begin
            if (chr_q == LAST_CHR) begin
              valid_q <= 1'b0;
              state_q <= ST_NEXT;
            end else begin
              chr_q  <= chr_d;
              x_q    <= x_d;
              y_q    <= y_d;
              code_q <= code_d;
            end
          end
        end
        ST_NEXT: begin
          if (idx_q == LAST_IDX) begin
            fin_q   <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            idx_q   <= idx_q + 9'd1;
            lat_q   <= LAT_INIT;
            state_q <= ST_ADDR;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy              = busy_q;
  assign addr              = idx_q;
  assign finished_register = fin_q;
  assign char_valid        = valid_q;
  assign char_x            = x_q;
  assign char_y            = y_q;
  assign char_code         = code_q;

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// Bench for reg_dump_sequencer: random register contents, a register source
// that is only valid exactly READ_LATENCY cycles after an address change,
// randomised / toggled / steady ready, and a queue-based scoreboard of the
// expected text stream built from hex strings.
module tb_reg_dump_sequencer;

  localparam int NR = 6;
  localparam int RL = 3;
  localparam int CB = 122;
  localparam int RB = 60;
`ifdef REG_DUMP_LABEL_EN
  localparam bit LABELS = 1'b1;
`else
  localparam bit LABELS = 1'b0;
`endif
  localparam int K = LABELS ? 12 : 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        char_ready = 1'b0;
  logic [31:0] register_value = '0;
  logic        busy;
  logic [8:0]  addr;
  logic        finished_register;
  logic        char_valid;
  logic [6:0]  char_x;
  logic [5:0]  char_y;
  logic [7:0]  char_code;

  always #5 clk = ~clk;

  reg_dump_sequencer #(
    .NUM_REGS     (NR),
    .READ_LATENCY (RL),
    .COL_BASE     (CB),
    .ROW_BASE     (RB)
  ) dut (
    .CLOCK_50          (clk),
    .resetn            (resetn),
    .start             (start),
    .busy              (busy),
    .addr              (addr),
    .register_value    (register_value),
    .finished_register (finished_register),
    .char_valid        (char_valid),
    .char_ready        (char_ready),
    .char_x            (char_x),
    .char_y            (char_y),
    .char_code         (char_code)
  );

  int errors = 0;
  int checks = 0;
  logic [20:0] exp_q[$];
  logic [31:0] mem [NR];
  int ncyc = 0;
  int n_xfer = 0;
  int fin_count = 0;
  int exp_fin = 0;
  int exp_dur = 0;
  int busy_rise_cyc = 0;
  int rmode = 0;
  string hexd = "0123456789ABCDEF";

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference text: each row is the optional "Rxx:" label followed by the
  // 8-digit uppercase hex value; column/row wrap to 7/6 bits.
  task automatic push_sweep();
    for (int i = 0; i < NR; i++) begin
      string s;
      s = "";
      if (LABELS) begin
        s = {"R", hexd.substr((i / 16) % 16, (i / 16) % 16), hexd.substr(i % 16, i % 16), ":"};
      end
      for (int j = 7; j >= 0; j--) begin
        int d;
        d = int'((mem[i] >> (4 * j)) & 32'hF);
        s = {s, hexd.substr(d, d)};
      end
      for (int j = 0; j < s.len(); j++) begin
        exp_q.push_back({7'((CB + j) % 128), 6'((RB + i) % 64), s[j]});
      end
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < NR; i++) mem[i] = $urandom;
  endtask

  // Register source: returns the addressed word only in the cycle exactly
  // READ_LATENCY cycles after addr changed (or a sweep began); junk otherwise,
  // so an early/late capture or a shadow that follows the bus is visible.
  int         age = 0;
  logic [8:0] src_addr_prev = '0;
  logic       src_busy_prev = 1'b0;
  always @(negedge clk) begin
    if (addr != src_addr_prev || (busy && !src_busy_prev)) age = 0;
    else if (age < 1000) age++;
    src_addr_prev = addr;
    src_busy_prev = busy;
    if (age == RL && int'(addr) < NR) register_value = mem[addr];
    else register_value = $urandom;
  end

  // Ready driver: 0 = tied high, 1 = random, 2 = toggle 1-0-1-0.
  always @(posedge clk) begin
    #2;
    case (rmode)
      1: char_ready = 1'($urandom_range(0, 1));
      2: char_ready = ~char_ready;
      default: char_ready = 1'b1;
    endcase
  end

  // Monitor / scoreboard.
  logic        held = 1'b0;
  logic [20:0] held_pay = '0;
  logic        busy_prev = 1'b0;
  always @(negedge clk) begin
    logic [20:0] pay;
    logic [20:0] e;
    ncyc++;
    pay = {char_x, char_y, char_code};
    if (!resetn) begin
      held = 1'b0;
    end else begin
      if (held) begin
        if (!char_valid) check("valid_dropped", 32'(char_valid), 32'd1);
        else check("stall_hold", 32'(pay), 32'(held_pay));
      end
      held = 1'b0;
      if (char_valid && char_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_char: got %0h expected none", pay);
        end else begin
          e = exp_q.pop_front();
          check("char", 32'(pay), 32'(e));
          $display("xfer x=%0d y=%0d code=%0h", char_x, char_y, char_code);
          n_xfer++;
        end
      end else if (char_valid) begin
        held = 1'b1;
        held_pay = pay;
      end
      if (busy && !busy_prev) begin
        busy_rise_cyc = ncyc;
        check("addr_at_start", 32'(addr), 32'd0);
      end
      if (finished_register) begin
        fin_count++;
        check("busy_in_done", 32'(busy), 32'd1);
        check("queue_empty_at_done", 32'(exp_q.size()), 32'd0);
        if (exp_dur != 0) check("sweep_cycles", 32'(ncyc - busy_rise_cyc), 32'(exp_dur));
      end
    end
    busy_prev = busy;
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_addr"}, 32'(addr), 32'd0);
    check({tag, "_fin"}, 32'(finished_register), 32'd0);
    check({tag, "_valid"}, 32'(char_valid), 32'd0);
    check({tag, "_x"}, 32'(char_x), 32'd0);
    check({tag, "_y"}, 32'(char_y), 32'd0);
    check({tag, "_code"}, 32'(char_code), 32'd0);
  endtask

  // Called at posedge+#1 with the DUT idle; returns one cycle after start is taken.
  task automatic begin_sweep(input int mode);
    rmode = mode;
    push_sweep();
    exp_fin++;
    exp_dur = (mode == 0) ? NR * (RL + K + 2) : 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_sweep(input int mode, input bit poke);
    int t;
    begin_sweep(mode);
    t = 0;
    while (!finished_register && t < 3000) begin
      start = poke && (t == 5);
      @(posedge clk); #1;
      t++;
    end
    check("sweep_done_in_time", 32'(t < 3000), 32'd1);
    // In DONE: a start here must be ignored as well.
    start = poke;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_done", 32'(busy), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("idle_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int t;
    int n0;
    for (int i = 0; i < NR; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    resetn = 1'b1;
    @(posedge clk); #1;

    fill_mem();
    mem[0] = 32'hFEEDF00D;
    mem[1] = 32'h0000ABCD;
    mem[5] = 32'h55555555;
    run_sweep(0, 1'b1);

    fill_mem();
    run_sweep(2, 1'b0);

    fill_mem();
    run_sweep(1, 1'b1);

    // Reset while register 3 is mid-row.
    fill_mem();
    n0 = n_xfer;
    begin_sweep(0);
    t = 0;
    while ((n_xfer - n0) < 3 * K + 2 && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    check("reset_point_reached", 32'(t < 2000), 32'd1);
    check("valid_before_reset", 32'(char_valid), 32'd1);
    resetn = 1'b0;
    @(posedge clk); #1;
    check_all_zero("midreset");
    resetn = 1'b1;
    exp_q.delete();
    exp_fin--;
    exp_dur = 0;
    repeat (3) @(posedge clk);
    #1;
    check("no_fin_after_reset", 32'(fin_count), 32'(exp_fin));

    fill_mem();
    run_sweep(0, 1'b0);

    repeat (10) @(posedge clk);
    #1;
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("finish_pulses", 32'(fin_count), 32'(exp_fin));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
